seq_mul_unit: RTL and testbench

Multi-cycle RV32M multiply unit for the pipelined core's EX stage. It computes MUL, MULH, MULHSU and MULHU with a shift-add algorithm, reusing one XLEN-bit ripple-carry adder for every arithmetic step:

- operand absolute value,
- partial-product accumulation,
- result negation.

The pipeline stalls on `busy` and captures `result` on `done`.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/NbitRCA.sv | 23 ++
 rtl/seq_mul_unit.sv | 188 ++++++++++++++++++
 tb/tb_seq_mul_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential RV32M multiply unit.
package mul_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StNegA,
        StNegB,
        StCalc,
        StFixLo,
        StFixHi,
        StDone
    } mul_state_t;

endpackage

// File: rtl/NbitRCA.sv
// N-bit ripple-carry adder; the single arithmetic resource of the multiply unit.
module NbitRCA #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    always_comb begin
        logic carry;
        carry = Cin;
        S     = '0;
        for (int i = 0; i < N; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier for MUL/MULH/MULHSU/MULHU, fixed latency of Xlen+5 cycles.
// Every arithmetic step (abs, accumulate, negate) goes through one shared ripple-carry adder.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned Xlen = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [Xlen-1:0] a_i,
    input  logic [Xlen-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [Xlen-1:0] result_o
);

    localparam int unsigned     CntW    = $clog2(Xlen);
    localparam logic [CntW-1:0] CntLast = CntW'(Xlen - 1);

    mul_state_t state_q, state_d;

    logic [1:0]      op_q, op_d;
    logic [Xlen-1:0] a_q, a_d, b_q, b_d;
    logic [Xlen-1:0] mcand_q, mcand_d;
    logic [Xlen-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [Xlen-1:0] result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            a_s_q, a_s_d, b_s_q, b_s_d, neg_q, neg_d, carry_q, carry_d;

    logic [Xlen-1:0] add_a, add_b, add_s;
    logic            add_cin, add_cout;

    NbitRCA #(
        .N(Xlen)
    ) u_rca (
        .A   (add_a),
        .B   (add_b),
        .Cin (add_cin),
        .S   (add_s),
        .Cout(add_cout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start_i) state_d = StNegA;
                StNegA:  state_d = StNegB;
                StNegB:  state_d = StCalc;
                StCalc:  if (cnt_q == CntLast) state_d = StFixLo;
                StFixLo: state_d = StFixHi;
                StFixHi: state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state_q != StIdle);
        done_o   = (state_q == StDone);
        result_o = result_q;
    end

    // Shared adder operand mux; inversion plus carry-in forms two's-complement negation.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            StNegA: begin
                add_a   = a_s_q ? ~a_q : a_q;
                add_cin = a_s_q;
            end
            StNegB: begin
                add_a   = b_s_q ? ~b_q : b_q;
                add_cin = b_s_q;
            end
            StCalc: begin
                add_a = hi_q;
                add_b = lo_q[0] ? mcand_q : '0;
            end
            StFixLo: begin
                add_a   = neg_q ? ~lo_q : lo_q;
                add_cin = neg_q;
            end
            StFixHi: begin
                add_a   = neg_q ? ~hi_q : hi_q;
                add_cin = carry_q & neg_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        a_s_d    = a_s_q;
        b_s_d    = b_s_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d  = op_i;
                    a_d   = a_i;
                    b_d   = b_i;
                    a_s_d = a_i[Xlen-1] & ((op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU));
                    b_s_d = b_i[Xlen-1] & (op_i == MUL_OP_MULH);
                    neg_d = a_s_d ^ b_s_d;
                end
            end
            StNegA: mcand_d = add_s;
            StNegB: begin
                hi_d  = '0;
                lo_d  = add_s;
                cnt_d = '0;
            end
            StCalc: begin
                // Adder carry-out becomes the new MSB of hi as the pair shifts right.
                hi_d  = {add_cout, add_s[Xlen-1:1]};
                lo_d  = {add_s[0], lo_q[Xlen-1:1]};
                cnt_d = cnt_q + CntW'(1);
            end
            StFixLo: begin
                lo_d    = add_s;
                carry_d = add_cout;
            end
            StFixHi: begin
                hi_d = add_s;
                if (!flush_i) begin
                    result_d = (op_q == MUL_OP_MUL) ? lo_q : add_s;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_s_q    <= 1'b0;
            b_s_q    <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_s_q    <= a_s_d;
            b_s_q    <= b_s_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed-vector bench for seq_mul_unit: latency, signed corners, busy/flush and async reset.
module tb_seq_mul_unit;
    import mul_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    seq_mul_unit #(
        .Xlen(32)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .result_o(result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; expects done first seen after edge E36.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk_i);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, " busy_after_E0"}, {31'b0, busy_o}, 32'd1);
        for (int k = 1; k <= 60 && n == 0; k++) begin
            @(negedge clk_i);
            if (done_o) n = k;
        end
        check({tag, " done_edge"}, n, 32'd36);
        check({tag, " result"}, result_o, exp);
        @(negedge clk_i);
        check({tag, " done_pulse_width"}, {31'b0, done_o}, 32'd0);
        check({tag, " busy_drop"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;

        // Reset state
        #3;
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst done", {31'b0, done_o}, 32'd0);
        check("rst result", result_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("idle busy", {31'b0, busy_o}, 32'd0);
        check("idle done", {31'b0, done_o}, 32'd0);

        do_op("mul_7x6", MUL_OP_MUL, 32'd7, 32'd6, 32'h0000002A);
        do_op("mulh_m1xm1", MUL_OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        do_op("mulhu_m1xm1", MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("mulhsu_m1x2", MUL_OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        do_op("mulh_min2", MUL_OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
        do_op("mul_minxm1", MUL_OP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_op("mulhu_big", MUL_OP_MULHU, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E);

        // start pulsed at E5 while busy must not disturb the running MUL 9x9
        @(negedge clk_i);
        op_i    = MUL_OP_MUL;
        a_i     = 32'd9;
        b_i     = 32'd9;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        op_i    = MUL_OP_MULHU;
        a_i     = 32'd2;
        b_i     = 32'd2;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        for (int k = 6; k <= 60 && n == 0; k++) begin
            @(negedge clk_i);
            if (done_o) n = k;
        end
        check("ignored_start done_edge", n, 32'd36);
        check("ignored_start result", result_o, 32'h00000051);
        @(negedge clk_i);
        check("ignored_start not_queued", {31'b0, busy_o}, 32'd0);

        // flush at E10 aborts with no done and result held
        @(negedge clk_i);
        a_i     = 32'd10;
        b_i     = 32'd10;
        op_i    = MUL_OP_MUL;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy", {31'b0, busy_o}, 32'd0);
        check("flush done", {31'b0, done_o}, 32'd0);
        check("flush result", result_o, 32'h00000051);
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        check("flush no_done", {31'b0, seen}, 32'd0);
        check("flush result_held", result_o, 32'h00000051);

        // start together with flush in IDLE is dropped
        @(negedge clk_i);
        start_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b0;
        check("start_flush busy", {31'b0, busy_o}, 32'd0);

        // asynchronous reset during CALC
        @(negedge clk_i);
        a_i     = 32'd4;
        b_i     = 32'd4;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst busy", {31'b0, busy_o}, 32'd0);
        check("async_rst result", result_o, 32'd0);
        check("async_rst done", {31'b0, done_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_op("mul_3x5", MUL_OP_MUL, 32'd3, 32'd5, 32'h0000000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
